mmio_console: RTL and testbench

//  Memory-mapped console/exit peripheral on the data-memory write port, between the riscv core and the

---
 rtl/mmio_console.sv | 130 +++++++++++++
 tb/tb_mmio_console.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// mmio_console: console/exit peripheral on the core's data-memory write port.
//   Stores to PUTC_ADDR queue a character; a store to EXIT_ADDR ends the program.
//   Every other store is forwarded to the data RAM.
//   Ports:
//     clk, reset                  clock and asynchronous active-high reset
//     dmem_wready/waddr/wdata/wstrb  core write request
//     io_stall                    core must hold and retry the current write
//     ram_wready                  write forwarded to the data RAM
//     tx_valid/tx_data/tx_ready   outgoing character stream
//     exit_valid/exit_code        sticky termination flag and exit code
//     char_count                  characters popped since reset
module mmio_console #(
  parameter logic [31:0] PUTC_ADDR = 32'h8000001c,
  parameter logic [31:0] EXIT_ADDR = 32'h8000002c,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        io_stall,
  output logic        ram_wready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        exit_valid,
  output logic [31:0] exit_code,
  output logic [31:0] char_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [DEPTH];
  logic            exit_valid_q;
  logic [31:0]     exit_code_q;
  logic [31:0]     char_count_q;

  logic addr_putc, addr_exit;
  logic hit_putc, hit_exit;
  logic empty, full, empty_next;
  logic push, pop;

  // Only byte lane 0 carries the character.
  logic unused_strb;
  assign unused_strb = ^dmem_wstrb[3:1];

  assign addr_putc = (dmem_waddr == PUTC_ADDR);
  assign addr_exit = (dmem_waddr == EXIT_ADDR);
  assign hit_putc  = dmem_wready && addr_putc && dmem_wstrb[0];
  assign hit_exit  = dmem_wready && addr_exit;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = !empty && tx_ready;
  // A full FIFO can still take a char when the head leaves in the same cycle.
  assign push = hit_putc && (state_q != DONE) && (!full || pop);

  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign empty_next = (wr_ptr_d == rd_ptr_d);

  assign io_stall   = (hit_putc && full && !pop) || (hit_exit && state_q == DRAIN);
  assign ram_wready = dmem_wready && !(addr_putc || addr_exit);

  assign tx_valid   = !empty;
  // Force zero when empty so stale entries never show after reset.
  assign tx_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign exit_valid = exit_valid_q;
  assign exit_code  = exit_code_q;
  assign char_count = char_count_q;

  // Storage array carries no reset; visibility is gated by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= dmem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      char_count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pop) begin
        char_count_q <= char_count_q + 32'd1;
      end
      case (state_q)
        RUN: begin
          if (hit_exit) begin
            exit_code_q <= dmem_wdata;
            if (empty) begin
              state_q      <= DONE;
              exit_valid_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Terminate only once the last buffered char has been taken.
          if (empty_next) begin
            state_q      <= DONE;
            exit_valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;

  localparam logic [31:0] PUTC  = 32'h8000001c;
  localparam logic [31:0] EXITA = 32'h8000002c;
  localparam int          DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        dmem_wready;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        io_stall;
  logic        ram_wready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic [31:0] char_count;

  mmio_console #(.PUTC_ADDR(PUTC), .EXIT_ADDR(EXITA), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .dmem_wready(dmem_wready), .dmem_waddr(dmem_waddr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .io_stall(io_stall), .ram_wready(ram_wready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .exit_valid(exit_valid), .exit_code(exit_code), .char_count(char_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of pending chars plus termination flags.
  logic [7:0]  q[$];
  bit          m_drain, m_done, m_ev;
  logic [31:0] m_code, m_cnt;

  // Last observed combinational outputs, for directed spot checks.
  logic obs_stall, obs_ram;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drain = 0; m_done = 0; m_ev = 0;
    m_code = '0; m_cnt = '0;
  endtask

  task automatic check_outputs(input string when);
    chk({when, "_tx_valid"},   tx_valid, q.size() != 0);
    chk({when, "_tx_data"},    tx_data, (q.size() != 0) ? q[0] : 8'h00);
    chk({when, "_exit_valid"}, exit_valid, m_ev);
    chk({when, "_exit_code"},  exit_code, m_code);
    chk({when, "_char_count"}, char_count, m_cnt);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic r);
    bit was_empty, pop_m, putc_a, exit_a, stall_m, ram_m;
    dmem_wready = we; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = s; tx_ready = r;
    #1;
    was_empty = (q.size() == 0);
    pop_m     = !was_empty && r;
    putc_a    = (a == PUTC);
    exit_a    = (a == EXITA);
    stall_m   = (we && putc_a && s[0] && q.size() == DEPTH && !pop_m) ||
                (we && exit_a && m_drain);
    ram_m     = we && !(putc_a || exit_a);
    obs_stall = io_stall;
    obs_ram   = ram_wready;
    chk("io_stall", io_stall, stall_m);
    chk("ram_wready", ram_wready, ram_m);
    chk("pre_tx_valid", tx_valid, !was_empty);
    // Apply the clock edge to the model.
    if (pop_m) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (we && putc_a && s[0] && !m_done && !stall_m) q.push_back(d[7:0]);
    if (m_drain) begin
      if (q.size() == 0) begin
        m_drain = 0; m_done = 1; m_ev = 1;
      end
    end else if (!m_done && we && exit_a) begin
      m_code = d;
      if (was_empty) begin
        m_done = 1; m_ev = 1;
      end else begin
        m_drain = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("post");
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, r);
  endtask

  // Called at a negedge: reset takes effect immediately, between edges.
  task automatic do_reset();
    reset = 1'b1;
    dmem_wready = 1'b0; tx_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_exit_valid", exit_valid, 1'b0);
    chk("rst_exit_code", exit_code, 32'h0);
    chk("rst_char_count", char_count, 32'h0);
    chk("rst_io_stall", io_stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; dmem_wready = 1'b0; dmem_waddr = '0; dmem_wdata = '0;
    dmem_wstrb = '0; tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: two back-to-back chars with the sink always ready.
    cycle(1'b1, PUTC, 32'h41, 4'h1, 1'b1);
    chk("t1_ram0", obs_ram, 1'b0);
    chk("t1_head0", tx_data, 8'h41);
    cycle(1'b1, PUTC, 32'h42, 4'h1, 1'b1);
    chk("t1_ram1", obs_ram, 1'b0);
    chk("t1_head1", tx_data, 8'h42);
    idle(1'b1);
    chk("t1_count", char_count, 32'd2);
    chk("t1_empty", tx_valid, 1'b0);

    // 2: fill to full, stall on the extra write, then accept it with a pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, PUTC, 32'h50 + i, 4'h1, 1'b0);
    chk("t2_not_stalled_last_fill", obs_stall, 1'b0);
    cycle(1'b1, PUTC, 32'h60, 4'h1, 1'b0);
    chk("t2_stall_full", obs_stall, 1'b1);
    cycle(1'b1, PUTC, 32'h60, 4'h1, 1'b1);
    chk("t2_stall_drop", obs_stall, 1'b0);
    chk("t2_head", tx_data, 8'h51);
    cycle(1'b1, PUTC, 32'h61, 4'h1, 1'b0);
    chk("t2_still_full", obs_stall, 1'b1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    chk("t2_count", char_count, 32'd19);

    // 3: exit while chars are buffered.
    cycle(1'b1, PUTC, 32'h61, 4'h1, 1'b0);
    cycle(1'b1, PUTC, 32'h62, 4'h1, 1'b0);
    cycle(1'b1, PUTC, 32'h63, 4'h1, 1'b0);
    cycle(1'b1, EXITA, 32'h5, 4'hf, 1'b0);
    chk("t3_drain_no_exit", exit_valid, 1'b0);
    cycle(1'b1, EXITA, 32'h7, 4'hf, 1'b0);
    chk("t3_second_exit_stall", obs_stall, 1'b1);
    idle(1'b1);
    chk("t3_pop1", exit_valid, 1'b0);
    idle(1'b1);
    chk("t3_pop2", exit_valid, 1'b0);
    idle(1'b1);
    chk("t3_pop3_exit", exit_valid, 1'b1);
    chk("t3_code", exit_code, 32'h5);

    // 4: writes after termination are swallowed.
    cycle(1'b1, PUTC, 32'h43, 4'h1, 1'b1);
    chk("t4_putc_nostall", obs_stall, 1'b0);
    chk("t4_no_tx", tx_valid, 1'b0);
    cycle(1'b1, EXITA, 32'h9, 4'hf, 1'b1);
    chk("t4_exit_nostall", obs_stall, 1'b0);
    chk("t4_code_frozen", exit_code, 32'h5);
    chk("t4_count_frozen", char_count, 32'd22);

    // 5: RAM pass-through and a PUTC with byte lane 0 disabled.
    do_reset();
    cycle(1'b1, 32'h00020000, 32'hAA, 4'hf, 1'b0);
    chk("t5_ram_fwd", obs_ram, 1'b1);
    chk("t5_ram_nopush", tx_valid, 1'b0);
    cycle(1'b1, PUTC, 32'h44, 4'h2, 1'b0);
    chk("t5_strb_ram", obs_ram, 1'b0);
    chk("t5_strb_nopush", tx_valid, 1'b0);

    // 6: reset in the middle of a drain.
    cycle(1'b1, PUTC, 32'h71, 4'h1, 1'b0);
    idle(1'b1);
    cycle(1'b1, PUTC, 32'h72, 4'h1, 1'b0);
    cycle(1'b1, PUTC, 32'h73, 4'h1, 1'b0);
    cycle(1'b1, EXITA, 32'h3, 4'hf, 1'b0);
    chk("t6_pre_count", char_count, 32'd1);
    chk("t6_pre_exit", exit_valid, 1'b0);
    do_reset();
    cycle(1'b1, EXITA, 32'h11, 4'hf, 1'b0);
    chk("t6_exit_now", exit_valid, 1'b1);
    chk("t6_code", exit_code, 32'h11);

    // Randomized traffic against the model, several reset episodes.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int n = 0; n < 400; n++) begin
        logic        we, r;
        logic [31:0] a;
        int          sel;
        we  = ($urandom_range(0, 3) != 0);
        r   = ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 63);
        if (sel < 30)      a = PUTC;
        else if (sel == 0 || sel == 63) a = EXITA;
        else if (sel < 35) a = PUTC + 32'd4;
        else               a = $urandom & 32'h0003fffc;
        cycle(we, a, $urandom, 4'($urandom_range(0, 15)), r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
